// File: rtl/uart_arb_pkg.sv
// Shared state encoding and header tag for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StSend,
    StWaitHi,
    StWaitLo
  } arb_state_e;

  localparam logic [3:0] HDR_TAG = 4'hA;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request searching upward from last_id_i+1.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] last_id_i,
  output logic           valid_o,
  output logic [N-1:0]   gnt_o,
  output logic [IdW-1:0] idx_o
);

  int unsigned cand;

  always_comb begin
    valid_o = 1'b0;
    gnt_o   = '0;
    idx_o   = '0;
    cand    = 0;
    // Offsets 1..N visit every index once, ending on last_id_i itself.
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(last_id_i) + off) % N;
      if (!valid_o && req_i[cand[IdW-1:0]]) begin
        valid_o                = 1'b1;
        idx_o                  = cand[IdW-1:0];
        gnt_o[cand[IdW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular sharing of one UART transmitter among NUM_REQ byte streams.
// Define UART_TX_ARB_HDR_EN to prefix every grant with a {HDR_TAG, id} header byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ   = 4,
  parameter int unsigned  MAX_BURST = 16,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 msg_done,
  output logic                 arb_busy
);

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] ready_q;
  logic [7:0]         tx_data_q;
  logic [7:0]         count_q;
  logic               tx_start_q;
  logic               msg_done_q;
  logic               arb_busy_q;
  logic               last_q;
  logic [ID_W-1:0]    last_id_q;

  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;

  logic               cur_valid;
  logic               cur_last;
  logic [7:0]         cur_data;

  rr_pick #(
    .N   (NUM_REQ),
    .IdW (ID_W)
  ) u_rr_pick (
    .req_i     (req_valid),
    .last_id_i (last_id_q),
    .valid_o   (pick_valid),
    .gnt_o     (pick_gnt),
    .idx_o     (pick_idx)
  );

  // last_id_q doubles as the index of the current owner while granted.
  assign cur_valid = req_valid[last_id_q];
  assign cur_last  = req_last[last_id_q];
  assign cur_data  = req_data[{last_id_q, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      ready_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      msg_done_q <= 1'b0;
      arb_busy_q <= 1'b0;
      last_q     <= 1'b0;
      count_q    <= '0;
      last_id_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      ready_q    <= '0;
      tx_start_q <= 1'b0;
      msg_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_q    <= pick_gnt;
            last_id_q  <= pick_idx;
            count_q    <= '0;
            last_q     <= 1'b0;
            arb_busy_q <= 1'b1;
`ifdef UART_TX_ARB_HDR_EN
            state_q    <= StHdr;
`else
            state_q    <= StSend;
`endif
          end
        end
`ifdef UART_TX_ARB_HDR_EN
        StHdr: begin
          tx_data_q  <= {HDR_TAG, 4'(last_id_q)};
          tx_start_q <= 1'b1;
          state_q    <= StWaitHi;
        end
`endif
        StSend: begin
          if (cur_valid) begin
            tx_data_q  <= cur_data;
            tx_start_q <= 1'b1;
            ready_q    <= grant_q;
            last_q     <= cur_last;
            if (count_q != MaxBurst) count_q <= count_q + 8'd1;
            state_q    <= StWaitHi;
          end else begin
            // A stalled owner gives the line up rather than blocking others.
            grant_q    <= '0;
            msg_done_q <= 1'b1;
            arb_busy_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        StWaitHi: begin
          if (tx_busy) state_q <= StWaitLo;
        end
        StWaitLo: begin
          if (!tx_busy) begin
            if (last_q || (count_q == MaxBurst)) begin
              grant_q    <= '0;
              msg_done_q <= 1'b1;
              arb_busy_q <= 1'b0;
              state_q    <= StIdle;
            end else begin
              state_q    <= StSend;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant     = grant_q;
  assign req_ready = ready_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign msg_done  = msg_done_q;
  assign arb_busy  = arb_busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among NUM_REQ byte-stream requesters.
- Arbitration is round-robin, on message boundaries. A requester holds the line until it sends a byte flagged last, stops offering data, or reaches MAX_BURST bytes.
- Sequences the transmitter one byte at a time: loads tx_data, pulses tx_start, then tracks tx_busy through rise and fall before sending the next byte.
- Sits between the requester clients and the transmitter; shares clk/rst with the transmitter and baud generator.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_BURST, 16, maximum payload bytes per grant before forced release (1..255).
- ID_W, $clog2(NUM_REQ), width of the grant index (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte offered.
- req_data  in  NUM_REQ*8  flattened bytes; requester i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  offered byte ends the message.
- req_ready  out  NUM_REQ  one-cycle pulse: byte taken from requester i.
- grant  out  NUM_REQ  one-hot owner of the line; all-zero when idle.
- tx_data  out  8  byte to the transmitter, held stable through the frame.
- tx_start  out  1  one-cycle start strobe to the transmitter.
- tx_busy  in  1  transmitter frame in progress.
- msg_done  out  1  one-cycle pulse when a grant is released.
- arb_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0 at clk edge):
  - State goes to IDLE.
  - grant, req_ready, tx_start, msg_done, arb_busy and tx_data all go to 0.
  - Round-robin pointer last_id goes to NUM_REQ-1, so requester 0 wins first.
  - Burst counter goes to 0.
  - A transmitter frame already in flight is not aborted; the arbiter simply forgets it.
- States: IDLE, SEND, WAIT_HI, WAIT_LO (plus HDR when the feature is on).
- IDLE:
  - If any req_valid is high, pick the first valid index searching upward from last_id+1, modulo NUM_REQ.
  - Register grant (one-hot), last_id=winner and count=0; go to SEND.
  - Arbitration latency: 1 cycle from valid to grant.
- SEND:
  - If req_valid[g]=1: tx_data<=req_data[g]; tx_start=1 and req_ready[g]=1 for exactly this cycle; latch req_last[g] into last_q; count++; go to WAIT_HI.
  - If req_valid[g]=0: release the grant, pulse msg_done, go to IDLE. A stalled requester never blocks the line.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. No timeout.
- WAIT_LO: wait for tx_busy=0, then:
  - if last_q or count==MAX_BURST: release the grant (grant=0), pulse msg_done, go to IDLE;
  - otherwise go to SEND.
- Minimum gap between tx_start pulses is 3 cycles plus the transmitter busy time.
- Inputs are ignored while not granted. req_ready is never high for a non-granted requester.
- Simultaneous requests resolve purely by round-robin order from last_id+1.
- A new request arriving in the same cycle msg_done pulses is arbitrated in the following IDLE cycle.
- count is 8-bit and saturates at MAX_BURST; it never wraps.
- grant changes only in IDLE, on release, and at reset.

Optional Feature:
- Macro: UART_TX_ARB_HDR_EN.
- Defined:
  - IDLE goes to HDR instead of SEND.
  - HDR sends the header byte {4'hA, 4'(winner id)} with a tx_start pulse and no req_ready.
  - Then WAIT_HI, WAIT_LO, SEND as normal.
  - The header does not count toward MAX_BURST.
  - If req_valid[g] is low at the first SEND after the header, the message is still released as normal.
- Undefined: no HDR state; payload bytes only.

Decomposition:
- Package uart_arb_pkg holds the state enum (IDLE, HDR, SEND, WAIT_HI, WAIT_LO) and the HDR_TAG=4'hA constant.
- One sub-module: rr_pick.
  - Combinational round-robin priority selector.
  - Inputs: req vector, last_id. Outputs: one-hot winner and index.
  - Reused by future bus arbiters.

Test Plan:
- Single requester:
  - Stimulus: req0 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33); bench holds tx_busy high 10 cycles after each start.
  - Response: exactly 3 tx_start pulses carrying 0x11, 0x22, 0x33; 3 req_ready[0] pulses; one msg_done; grant returns to 0.
- Contention:
  - Stimulus: req0..3 all valid from reset, each sending a 1-byte message.
  - Response: grant order 0, 1, 2, 3; then with req1 and req3 re-asserted, order 1, then 3.
- Burst limit:
  - Stimulus: MAX_BURST=4; req2 streams 6 bytes with no last, req0 also valid.
  - Response: release after byte 4; req0 granted next; req2 resumes afterwards.
- Stall release:
  - Stimulus: req1 drops valid after its first byte.
  - Response: msg_done pulses; grant returns to 0; pending req2 is granted 1 cycle later.
- Reset mid-frame:
  - Stimulus: rst low during WAIT_LO.
  - Response: next edge shows all outputs 0 and state IDLE; after reset release, req0 wins first.
- With UART_TX_ARB_HDR_EN:
  - Stimulus: req3 sends the single byte 0x5C.
  - Response: tx bytes 0xA3 then 0x5C; only 1 req_ready pulse.
